// File: rtl/alu_stateful_pkg.sv
// rtl/alu_stateful_pkg.sv - opcode and FSM state encodings shared by alu_stateful
package alu_stateful_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_FADD  = 4'b0111;
  localparam logic [3:0] OP_STORE = 4'b1000;
  localparam logic [3:0] OP_ADDI  = 4'b1001;
  localparam logic [3:0] OP_SUBI  = 4'b1010;
  localparam logic [3:0] OP_LOAD  = 4'b1011;

  typedef enum logic [1:0] {
    IDLE_S = 2'd0,
    RD_S   = 2'd1,
    EX_S   = 2'd2,
    OUT_S  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_sdp_ram.sv
// rtl/alu_sdp_ram.sv - simple dual-port state RAM, synchronous read-first, muxed write port
module alu_sdp_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  dp_wr_en,
  input  logic [ADDR_WIDTH-1:0] dp_wr_addr,
  input  logic [DATA_WIDTH-1:0] dp_wr_data,
  input  logic                  ctrl_wr_en,
  input  logic [ADDR_WIDTH-1:0] ctrl_wr_addr,
  input  logic [DATA_WIDTH-1:0] ctrl_wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  // Datapath write owns the single write port; control write uses it otherwise
  always_comb begin
    wr_en   = ctrl_wr_en;
    wr_addr = ctrl_wr_addr;
    wr_data = ctrl_wr_data;
    if (dp_wr_en) begin
      wr_en   = 1'b1;
      wr_addr = dp_wr_addr;
      wr_data = dp_wr_data;
    end
  end

  // Read samples the array before a same-edge write lands (read-first); contents are never reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/alu_stateful.sv
// rtl/alu_stateful.sv - stateful action ALU, fixed 3-cycle latency; ALU_SATURATE_EN selects saturating add/sub
module alu_stateful #(
  parameter int STAGE_ID   = 0,
  parameter int ACTION_LEN = 25,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ACTION_LEN-1:0] action_in,
  input  logic                  action_valid,
  output logic                  action_ready,
  input  logic [DATA_WIDTH-1:0] operand_1_in,
  input  logic [DATA_WIDTH-1:0] operand_2_in,
  input  logic [DATA_WIDTH-1:0] operand_3_in,
  output logic [DATA_WIDTH-1:0] container_out,
  output logic                  container_out_valid,
  input  logic                  ctrl_wr_en,
  input  logic [ADDR_WIDTH-1:0] ctrl_wr_addr,
  input  logic [DATA_WIDTH-1:0] ctrl_wr_data,
  output logic                  ctrl_wr_ready
);

  import alu_stateful_pkg::*;

  // Stage index is informational only
  localparam int unused_stage_id = STAGE_ID;

  state_t                state_q, state_d;
  logic [3:0]            opcode_q, opcode_d;
  logic [DATA_WIDTH-1:0] op1_q, op1_d;
  logic [DATA_WIDTH-1:0] op2_q, op2_d;
  logic [DATA_WIDTH-1:0] op3_q, op3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] container_out_q, container_out_d;

  logic                  accept;
  logic                  ctrl_wr_fire;
  logic                  dp_wr_en;
  logic [DATA_WIDTH-1:0] dp_wr_data;
  logic [DATA_WIDTH-1:0] ram_rd_data;
  logic [DATA_WIDTH-1:0] fadd_sum;
  logic [DATA_WIDTH-1:0] result;
  logic [3:0]            opcode_in;
  logic                  unused_action_bits;

  assign opcode_in          = action_in[ACTION_LEN-1 -: 4];
  assign unused_action_bits = ^action_in[ACTION_LEN-5:0];

  assign action_ready        = (state_q == IDLE_S);
  assign ctrl_wr_ready       = (state_q != EX_S);
  assign accept              = action_valid && action_ready;
  assign ctrl_wr_fire        = ctrl_wr_en && ctrl_wr_ready;
  assign container_out       = container_out_q;
  assign container_out_valid = (state_q == OUT_S);

`ifdef ALU_SATURATE_EN
  function automatic logic [DATA_WIDTH-1:0] add_op(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : s[DATA_WIDTH-1:0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sub_op(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
    return (a < b) ? {DATA_WIDTH{1'b0}} : (a - b);
  endfunction
`else
  function automatic logic [DATA_WIDTH-1:0] add_op(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
    return a + b;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sub_op(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
    return a - b;
  endfunction
`endif

  // Result and datapath RAM write from the latched operands and the RAM read data
  always_comb begin
    fadd_sum   = add_op(ram_rd_data, op1_q);
    result     = op3_q;
    dp_wr_en   = 1'b0;
    dp_wr_data = op1_q;
    case (opcode_q)
      OP_ADD, OP_ADDI: result = add_op(op1_q, op2_q);
      OP_SUB, OP_SUBI: result = sub_op(op1_q, op2_q);
      OP_STORE: begin
        result     = op3_q;
        dp_wr_en   = (state_q == EX_S);
        dp_wr_data = op1_q;
      end
      OP_LOAD: result = ram_rd_data;
      OP_FADD: begin
        result     = fadd_sum;
        dp_wr_en   = (state_q == EX_S);
        dp_wr_data = fadd_sum;
      end
      default: result = op3_q;
    endcase
  end

  // Next-state and operand latching: accept in IDLE_S, then walk RD/EX/OUT unconditionally
  always_comb begin
    state_d         = state_q;
    opcode_d        = opcode_q;
    op1_d           = op1_q;
    op2_d           = op2_q;
    op3_d           = op3_q;
    addr_d          = addr_q;
    container_out_d = container_out_q;
    case (state_q)
      IDLE_S: begin
        if (accept) begin
          opcode_d = opcode_in;
          op1_d    = operand_1_in;
          op2_d    = operand_2_in;
          op3_d    = operand_3_in;
          addr_d   = operand_2_in[ADDR_WIDTH-1:0];
          state_d  = RD_S;
        end
      end
      RD_S: state_d = EX_S;
      EX_S: begin
        container_out_d = result;
        state_d         = OUT_S;
      end
      OUT_S: state_d = IDLE_S;
      default: state_d = IDLE_S;
    endcase
  end

  // State and operand registers; reset drops any in-flight action and its RAM write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE_S;
      opcode_q        <= '0;
      op1_q           <= '0;
      op2_q           <= '0;
      op3_q           <= '0;
      addr_q          <= '0;
      container_out_q <= '0;
    end else begin
      state_q         <= state_d;
      opcode_q        <= opcode_d;
      op1_q           <= op1_d;
      op2_q           <= op2_d;
      op3_q           <= op3_d;
      addr_q          <= addr_d;
      container_out_q <= container_out_d;
    end
  end

  alu_sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk          (clk),
    .dp_wr_en     (dp_wr_en),
    .dp_wr_addr   (addr_q),
    .dp_wr_data   (dp_wr_data),
    .ctrl_wr_en   (ctrl_wr_fire),
    .ctrl_wr_addr (ctrl_wr_addr),
    .ctrl_wr_data (ctrl_wr_data),
    .rd_en        (accept),
    .rd_addr      (operand_2_in[ADDR_WIDTH-1:0]),
    .rd_data      (ram_rd_data)
  );

endmodule

// File: tb/tb_alu_stateful.sv
// tb/tb_alu_stateful.sv - directed self-checking bench for alu_stateful
module tb_alu_stateful;

  import alu_stateful_pkg::*;

  localparam int AL = 25;
  localparam int DW = 32;
  localparam int AW = 5;

`ifdef ALU_SATURATE_EN
  localparam logic [31:0] EXP_SUB  = 32'h0000_0000;
  localparam logic [31:0] EXP_ADDI = 32'hFFFF_FFFF;
  localparam logic [31:0] EXP_F2   = 32'hFFFF_FFFF;
  localparam logic [31:0] EXP_F3   = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] EXP_SUB  = 32'hFFFF_FFFE;
  localparam logic [31:0] EXP_ADDI = 32'h0000_0001;
  localparam logic [31:0] EXP_F2   = 32'h0000_0000;
  localparam logic [31:0] EXP_F3   = 32'h0000_0001;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AL-1:0] action_in;
  logic          action_valid;
  logic          action_ready;
  logic [DW-1:0] operand_1_in, operand_2_in, operand_3_in;
  logic [DW-1:0] container_out;
  logic          container_out_valid;
  logic          ctrl_wr_en;
  logic [AW-1:0] ctrl_wr_addr;
  logic [DW-1:0] ctrl_wr_data;
  logic          ctrl_wr_ready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_stateful #(
    .STAGE_ID   (0),
    .ACTION_LEN (AL),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .action_in           (action_in),
    .action_valid        (action_valid),
    .action_ready        (action_ready),
    .operand_1_in        (operand_1_in),
    .operand_2_in        (operand_2_in),
    .operand_3_in        (operand_3_in),
    .container_out       (container_out),
    .container_out_valid (container_out_valid),
    .ctrl_wr_en          (ctrl_wr_en),
    .ctrl_wr_addr        (ctrl_wr_addr),
    .ctrl_wr_data        (ctrl_wr_data),
    .ctrl_wr_ready       (ctrl_wr_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_action(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c);
    action_in    = {op, {(AL-4){1'b0}}};
    operand_1_in = a;
    operand_2_in = b;
    operand_3_in = c;
    action_valid = 1'b1;
  endtask

  task automatic ctrl_write(input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge clk);
    ctrl_wr_en   = 1'b1;
    ctrl_wr_addr = a;
    ctrl_wr_data = d;
    @(posedge clk);
    #1 ctrl_wr_en = 1'b0;
  endtask

  // One action from IDLE; optional control write in the accept cycle
  task automatic run_action(input string tag, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] c, input logic [31:0] exp,
                            input logic cw_en, input logic [AW-1:0] cw_addr,
                            input logic [31:0] cw_data);
    int lat;
    @(negedge clk);
    check({tag, "_ready_before"}, action_ready, 1);
    set_action(op, a, b, c);
    ctrl_wr_en   = cw_en;
    ctrl_wr_addr = cw_addr;
    ctrl_wr_data = cw_data;
    @(posedge clk);
    #1;
    action_valid = 1'b0;
    ctrl_wr_en   = 1'b0;
    lat = 0;
    while (lat < 8) begin
      @(negedge clk);
      lat++;
      if (container_out_valid) break;
    end
    check({tag, "_latency"}, lat, 3);
    check({tag, "_result"}, container_out, exp);
    @(negedge clk);
    check({tag, "_valid_one_cycle"}, container_out_valid, 0);
    check({tag, "_ready_after"}, action_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] fadd_exp [3];
    int          fadd_cyc [3];
    int          k;
    int          strobes;

    fadd_exp[0] = 32'hFFFF_FFFF;
    fadd_exp[1] = EXP_F2;
    fadd_exp[2] = EXP_F3;
    fadd_cyc[0] = 3;
    fadd_cyc[1] = 7;
    fadd_cyc[2] = 11;

    rst_n        = 1'b0;
    action_in    = '0;
    action_valid = 1'b0;
    operand_1_in = '0;
    operand_2_in = '0;
    operand_3_in = '0;
    ctrl_wr_en   = 1'b0;
    ctrl_wr_addr = '0;
    ctrl_wr_data = '0;

    repeat (2) @(negedge clk);
    check("rst_container_out", container_out, 0);
    check("rst_valid", container_out_valid, 0);
    check("rst_action_ready", action_ready, 1);
    check("rst_ctrl_wr_ready", ctrl_wr_ready, 1);
    rst_n = 1'b1;

    run_action("add", OP_ADD, 32'd5, 32'd7, 32'd0, 32'd12, 1'b0, '0, '0);
    run_action("sub", OP_SUB, 32'd3, 32'd5, 32'd0, EXP_SUB, 1'b0, '0, '0);
    run_action("addi", OP_ADDI, 32'hFFFF_FFFF, 32'd2, 32'd0, EXP_ADDI, 1'b0, '0, '0);
    run_action("subi", OP_SUBI, 32'd10, 32'd3, 32'd0, 32'd7, 1'b0, '0, '0);
    run_action("other_op", 4'b0011, 32'd1, 32'd2, 32'h1234, 32'h1234, 1'b0, '0, '0);

    ctrl_write(5'd4, 32'h10);
    run_action("load4", OP_LOAD, 32'd0, 32'd4, 32'd0, 32'h10, 1'b0, '0, '0);
    run_action("store31", OP_STORE, 32'hABCD, 32'd31, 32'h55, 32'h55, 1'b0, '0, '0);
    run_action("load31", OP_LOAD, 32'd0, 32'd31, 32'd0, 32'hABCD, 1'b0, '0, '0);

    ctrl_write(5'd5, 32'h11);
    run_action("read_first", OP_LOAD, 32'd0, 32'd5, 32'd0, 32'h11, 1'b1, 5'd5, 32'h22);
    run_action("load5", OP_LOAD, 32'd0, 32'd5, 32'd0, 32'h22, 1'b0, '0, '0);

    // Three fetch-adds with action_valid held; busy-cycle valids must be ignored
    ctrl_write(5'd2, 32'hFFFF_FFFE);
    @(negedge clk);
    set_action(OP_FADD, 32'd1, 32'd2, 32'd0);
    k = 0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge clk);
      if (container_out_valid) begin
        if (k < 3) begin
          check($sformatf("fadd%0d_cycle", k), cyc, fadd_cyc[k]);
          check($sformatf("fadd%0d_result", k), container_out, fadd_exp[k]);
        end
        k++;
      end
      if (cyc == 12) action_valid = 1'b0;
    end
    check("fadd_strobe_count", k, 3);
    run_action("load2", OP_LOAD, 32'd0, 32'd2, 32'd0, EXP_F3, 1'b0, '0, '0);

    // Control write held across EX_S of a store to another address
    @(negedge clk);
    set_action(OP_STORE, 32'h99, 32'd9, 32'h5);
    @(posedge clk);
    #1 action_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    ctrl_wr_en   = 1'b1;
    ctrl_wr_addr = 5'd10;
    ctrl_wr_data = 32'hAA;
    check("hold_wr_ready_ex", ctrl_wr_ready, 0);
    @(negedge clk);
    check("hold_wr_ready_out", ctrl_wr_ready, 1);
    check("hold_store_valid", container_out_valid, 1);
    check("hold_store_result", container_out, 32'h5);
    @(posedge clk);
    #1 ctrl_wr_en = 1'b0;
    run_action("load9", OP_LOAD, 32'd0, 32'd9, 32'd0, 32'h99, 1'b0, '0, '0);
    run_action("load10", OP_LOAD, 32'd0, 32'd10, 32'd0, 32'hAA, 1'b0, '0, '0);

    // Reset during RD_S of a store discards the pending write and the strobe
    ctrl_write(5'd7, 32'h1);
    @(negedge clk);
    set_action(OP_STORE, 32'hDEAD, 32'd7, 32'h77);
    @(posedge clk);
    #1 action_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_container_out", container_out, 0);
    check("midrst_action_ready", action_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    strobes = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      if (container_out_valid) strobes++;
    end
    check("midrst_no_strobe", strobes, 0);
    check("midrst_out_zero", container_out, 0);
    run_action("load7", OP_LOAD, 32'd0, 32'd7, 32'd0, 32'h1, 1'b0, '0, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_stateful.md
Name: alu_stateful

Overview:
- Next-generation stateful action ALU for RMT action stages.
- Parametrised in data width and state-RAM depth.
- Adds an atomic fetch-add (counter) operation, an explicit accept handshake, a control-plane RAM write port, and a fixed 3-cycle latency.
- Sits between the sub_action operand crossbar and PHV re-assembly; one instance per stateful container slot.

Parameters:
- STAGE_ID, 0, stage index (informational, no behavioural effect).
- ACTION_LEN, 25, action word width; opcode is always action_in[ACTION_LEN-1:ACTION_LEN-4].
- DATA_WIDTH, 32, operand, container and RAM word width.
- ADDR_WIDTH, 5, state RAM address width; depth = 2**ADDR_WIDTH.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- action_in  in  ACTION_LEN  action word.
- action_valid  in  1  action and operands valid.
- action_ready  out  1  ALU can accept an action this cycle.
- operand_1_in  in  DATA_WIDTH  op1 (header field).
- operand_2_in  in  DATA_WIDTH  op2 (field/immediate; low ADDR_WIDTH bits = RAM address for RAM ops).
- operand_3_in  in  DATA_WIDTH  original container value (pass-through).
- container_out  out  DATA_WIDTH  result.
- container_out_valid  out  1  one-cycle result strobe.
- ctrl_wr_en  in  1  control-plane RAM write request.
- ctrl_wr_addr  in  ADDR_WIDTH  control write address.
- ctrl_wr_data  in  DATA_WIDTH  control write data.
- ctrl_wr_ready  out  1  control write accepted this cycle.

Behaviour:
- Reset (async, rst_n=0) forces:
  - state IDLE_S;
  - container_out=0, container_out_valid=0;
  - action_ready=1, ctrl_wr_ready=1;
  - all internal registers 0.
- RAM contents are not reset.
- FSM states: IDLE_S -> RD_S -> EX_S -> OUT_S -> IDLE_S. Each transition takes one cycle, unconditionally after accept.
- Accept: action_valid && action_ready in IDLE_S.
  - Latch opcode, op1, op3 and addr = operand_2_in[ADDR_WIDTH-1:0].
  - Issue the RAM read at addr in the same cycle.
- action_ready = (state == IDLE_S). action_valid outside IDLE_S is ignored (not queued).
- RD_S: synchronous RAM read data returns at the end of this state.
- EX_S: compute result; perform any datapath RAM write.
- OUT_S: container_out_valid=1 for exactly one cycle. container_out holds its value until the next OUT_S.
- Latency: accept at cycle T -> valid at T+3. Maximum throughput is one action per 4 cycles.
- Opcodes (all arithmetic is modulo 2**DATA_WIDTH, unsigned):
  - 0001 add, 1001 addi: op1+op2.
  - 0010 sub, 1010 subi: op1-op2.
  - 1000 store: ram[addr]=op1; result=op3.
  - 1011 load: result=ram[addr].
  - 0111 fetch-add: ram[addr]=ram[addr]+op1; result = the new value.
  - Any other opcode: result=op3, no RAM write.
- Because actions are serialised, the EX_S write is always visible to the next accepted action's read (no hazard logic).
- Control write port:
  - ctrl_wr_ready = (state != EX_S).
  - A write with ctrl_wr_en && ctrl_wr_ready commits the same cycle.
  - In EX_S, ctrl_wr_en must be held by the requester until ready.
  - A control write in the accept cycle to the address being read returns the old data (read-first RAM).
- Reset asserted mid-operation: FSM returns to IDLE_S, no valid strobe, pending datapath write discarded.

Optional Feature:
- Macro: ALU_SATURATE_EN.
- Defined:
  - add/addi/fetch-add clamp at 2**DATA_WIDTH-1;
  - sub/subi clamp at 0.
  - Saturation also applies to the value written to RAM by fetch-add.
- Undefined: wrap-around arithmetic as above. Ports and latency are identical in both builds.

Decomposition:
- Package alu_stateful_pkg holds:
  - opcode localparams OP_ADD, OP_SUB, OP_ADDI, OP_SUBI, OP_STORE, OP_LOAD, OP_FADD;
  - state encodings IDLE_S, RD_S, EX_S, OUT_S (2-bit).
- Sub-module alu_sdp_ram:
  - parametrised simple dual-port RAM (DATA_WIDTH, ADDR_WIDTH), inferred, not IP;
  - write port muxed: datapath write in EX_S, else control write;
  - read port synchronous, read-first.

Test Plan:
- Reset then add op1=5, op2=7 -> action_ready low 3 cycles; container_out=12 with valid at T+3 for 1 cycle; ready high at T+4.
- sub op1=3, op2=5 -> 0xFFFFFFFE (default build); 0 with ALU_SATURATE_EN.
- ctrl write ram[4]=0x10, then load addr=4 -> 0x10. Then store addr=31, op1=0xABCD, op3=0x55 -> 0x55. Then load addr=31 -> 0xABCD.
- ram[2]=0xFFFFFFFE, fetch-add op1=1 three times back-to-back (valid held high):
  - results 0xFFFFFFFF, 0x0, 0x1 (default build);
  - 0xFFFFFFFF ×3 with ALU_SATURATE_EN;
  - action_valid during busy cycles is ignored.
- ctrl_wr_en held through EX_S of a store to another address -> ctrl_wr_ready low that cycle; both writes land; subsequent loads return both values.
- rst_n pulsed low during RD_S of a store to addr=7 (ram[7]=0x1 prior) -> no valid strobe; container_out=0; later load addr=7 returns 0x1.
